// File: rtl/sram_1rw1r_array.sv
// 1RW + 1R SRAM model: lane write mask, write-first forwarding to port 1, post-reset self-clear,
// registered reads with 1 or 2 cycles of latency. Lane parity is enabled by defining SRAM_PARITY_EN.
module sram_1rw1r_array #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 4,
  parameter int WMASK_GRAN = 8,
  parameter int READ_LAT   = 1,
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_GRAN,
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  output logic                  ready,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  perr0,
  output logic                  perr1,
  input  logic                  pinj0
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  r_ready;
  logic                  w_ready_nxt;
  logic                  w_init_we;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // INIT zeroes one word per edge; ready rises on the edge that clears the last word.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    w_init_we   = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we = 1'b1;
        w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
        if (r_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
          w_ready_nxt = 1'b1;
        end else begin
          w_ready_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  assign ready = r_ready;

  logic                  w_cap0;
  logic                  w_cap1;
  logic                  r_we0;
  logic                  r_re0;
  logic                  r_re1;
  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic [DATA_WIDTH-1:0] r_din0;
  logic [NUM_WMASKS-1:0] r_wmask0;

  assign w_cap0 = r_ready & ~csb0;
  assign w_cap1 = r_ready & ~csb1;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_we0    <= 1'b0;
      r_re0    <= 1'b0;
      r_re1    <= 1'b0;
      r_addr0  <= '0;
      r_addr1  <= '0;
      r_din0   <= '0;
      r_wmask0 <= '0;
    end else begin
      r_we0 <= w_cap0 & ~web0;
      r_re0 <= w_cap0 & web0;
      r_re1 <= w_cap1;
      if (w_cap0) begin
        r_addr0  <= addr0;
        r_din0   <= din0;
        r_wmask0 <= wmask0;
      end
      if (w_cap1) begin
        r_addr1 <= addr1;
      end
    end
  end

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] w_bitmask;
  logic [DATA_WIDTH-1:0] w_rd0;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_coll;
  logic                  w_perr0;
  logic                  w_perr1;

  always_comb begin
    w_bitmask = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      w_bitmask[i*WMASK_GRAN +: WMASK_GRAN] = {WMASK_GRAN{r_wmask0[i]}};
    end
  end

  assign w_rd0    = r_mem[r_addr0];
  assign w_rd1    = r_mem[r_addr1];
  // Merged word is both the write-back value and the write-first data forwarded to port 1.
  assign w_merged = (r_din0 & w_bitmask) | (w_rd0 & ~w_bitmask);
  assign w_coll   = r_we0 & r_re1 & (r_addr0 == r_addr1);

  always_ff @(posedge clk0) begin
    if (w_init_we) begin
      r_mem[r_cnt] <= '0;
    end else if (r_we0) begin
      r_mem[r_addr0] <= w_merged;
    end
  end

`ifdef SRAM_PARITY_EN
  function automatic logic [NUM_WMASKS-1:0] lane_parity(input logic [DATA_WIDTH-1:0] d);
    logic [NUM_WMASKS-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      p[i] = ^d[i*WMASK_GRAN +: WMASK_GRAN];
    end
    return p;
  endfunction

  logic                  r_pinj0;
  logic [NUM_WMASKS-1:0] r_par [RAM_DEPTH];
  logic [NUM_WMASKS-1:0] w_par_new;
  logic [NUM_WMASKS-1:0] w_par_merged;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_pinj0 <= 1'b0;
    end else if (w_cap0) begin
      r_pinj0 <= pinj0;
    end
  end

  assign w_par_new    = lane_parity(r_din0) ^ {{(NUM_WMASKS-1){1'b0}}, r_pinj0};
  assign w_par_merged = (w_par_new & r_wmask0) | (r_par[r_addr0] & ~r_wmask0);
  assign w_perr0      = |(lane_parity(w_rd0) ^ r_par[r_addr0]);
  assign w_perr1      = w_coll ? |(lane_parity(w_merged) ^ w_par_merged)
                               : |(lane_parity(w_rd1) ^ r_par[r_addr1]);

  always_ff @(posedge clk0) begin
    if (w_init_we) begin
      r_par[r_cnt] <= '0;
    end else if (r_we0) begin
      r_par[r_addr0] <= w_par_merged;
    end
  end
`else
  logic w_unused_pinj;
  assign w_unused_pinj = pinj0;
  assign w_perr0       = 1'b0;
  assign w_perr1       = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] r_s1_d0;
  logic [DATA_WIDTH-1:0] r_s1_d1;
  logic                  r_s1_v0;
  logic                  r_s1_v1;
  logic                  r_s1_p0;
  logic                  r_s1_p1;

  // Data registers only load on a read so dout holds across writes and idle cycles.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_s1_d0 <= '0;
      r_s1_d1 <= '0;
      r_s1_v0 <= 1'b0;
      r_s1_v1 <= 1'b0;
      r_s1_p0 <= 1'b0;
      r_s1_p1 <= 1'b0;
    end else begin
      r_s1_v0 <= r_re0;
      r_s1_v1 <= r_re1;
      r_s1_p0 <= r_re0 & w_perr0;
      r_s1_p1 <= r_re1 & w_perr1;
      if (r_re0) begin
        r_s1_d0 <= w_rd0;
      end
      if (r_re1) begin
        r_s1_d1 <= w_coll ? w_merged : w_rd1;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_s2_d0;
      logic [DATA_WIDTH-1:0] r_s2_d1;
      logic                  r_s2_v0;
      logic                  r_s2_v1;
      logic                  r_s2_p0;
      logic                  r_s2_p1;

      always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
          r_s2_d0 <= '0;
          r_s2_d1 <= '0;
          r_s2_v0 <= 1'b0;
          r_s2_v1 <= 1'b0;
          r_s2_p0 <= 1'b0;
          r_s2_p1 <= 1'b0;
        end else begin
          r_s2_v0 <= r_s1_v0;
          r_s2_v1 <= r_s1_v1;
          r_s2_p0 <= r_s1_p0;
          r_s2_p1 <= r_s1_p1;
          if (r_s1_v0) begin
            r_s2_d0 <= r_s1_d0;
          end
          if (r_s1_v1) begin
            r_s2_d1 <= r_s1_d1;
          end
        end
      end

      assign dout0       = r_s2_d0;
      assign dout1       = r_s2_d1;
      assign dout0_valid = r_s2_v0;
      assign dout1_valid = r_s2_v1;
      assign perr0       = r_s2_p0;
      assign perr1       = r_s2_p1;
    end else begin : g_lat1
      assign dout0       = r_s1_d0;
      assign dout1       = r_s1_d1;
      assign dout0_valid = r_s1_v0;
      assign dout1_valid = r_s1_v1;
      assign perr0       = r_s1_p0;
      assign perr1       = r_s1_p1;
    end
  endgenerate

endmodule
